icache_fetch_ctrl: RTL and testbench

ICACHE_FETCH_CTRL -- requirements
Module: icache_fetch_ctrl

---
 rtl/ariane_pkg.sv | 32 +++
 rtl/icache_fetch_ctrl.sv | 174 +++++++++++++++++
 tb/tb_icache_fetch_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared types for the instruction-fetch controller: TLB request/response
// structs, address widths and the controller FSM state encoding.
package ariane_pkg;

    localparam int unsigned VLEN = 64;
    localparam int unsigned PLEN = 56;

    typedef struct packed {
        logic            fetch_req;
        logic [VLEN-1:0] fetch_vaddr;
    } icache_arsp_t;

    typedef struct packed {
        logic            fetch_valid;
        logic [PLEN-1:0] fetch_paddr;
    } icache_areq_t;

    // IDLE must stay at encoding 0 so the debug state reads 0 out of reset.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        XLATE    = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        RESP     = 3'd4,
        DRAIN    = 3'd5
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [VLEN-1:0] vaddr);
        return vaddr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/icache_fetch_ctrl.sv
// Single-word instruction fetch controller: translate via TLB, read one word
// from memory, return it to the frontend. At most one memory read in flight.
module icache_fetch_ctrl
    import ariane_pkg::*;
#(
    parameter int unsigned XLATE_TIMEOUT = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    dreq_valid_i,
    output logic                    dreq_ready_o,
    input  logic [VLEN-1:0]         dreq_vaddr_i,
    output icache_arsp_t            areq_o,
    input  icache_areq_t            areq_i,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic [PLEN-1:0]         mem_addr_o,
    input  logic                    mem_rvalid_i,
    input  logic [31:0]             mem_rdata_i,
    output logic                    drsp_valid_o,
    input  logic                    drsp_ready_i,
    output logic [VLEN-1:0]         drsp_vaddr_o,
    output logic [31:0]             drsp_data_o,
    output logic                    drsp_err_o,
    output fetch_state_e            dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // once raised, valid and its payload hold until that edge (or a flush).

    localparam int unsigned CNT_W = $clog2(XLATE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLATE_TIMEOUT - 1);

    fetch_state_e    r_state;
    fetch_state_e    w_next_state;
    logic [CNT_W-1:0] r_xlate_cnt;
    logic [VLEN-1:0] r_vaddr;
    logic [PLEN-1:0] r_paddr;
    logic [31:0]     r_data;
    logic            r_err;

    logic            w_accept;
    logic            w_xlate_expired;

    assign w_accept        = (r_state == IDLE) && dreq_valid_i;
    assign w_xlate_expired = !areq_i.fetch_valid && (r_xlate_cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Flush has priority over every other event in the states it affects.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (dreq_valid_i) begin
                    w_next_state = is_word_aligned(dreq_vaddr_i) ? XLATE : RESP;
                end
            end
            XLATE: begin
                if (flush_i) begin
                    w_next_state = IDLE;
                end else if (areq_i.fetch_valid) begin
                    w_next_state = MEM_REQ;
                end else if (w_xlate_expired) begin
                    w_next_state = RESP;
                end
            end
            MEM_REQ: begin
                if (mem_gnt_i) begin
                    w_next_state = flush_i ? DRAIN : MEM_WAIT;
                end else if (flush_i) begin
                    w_next_state = IDLE;
                end
            end
            MEM_WAIT: begin
                if (flush_i) begin
                    w_next_state = mem_rvalid_i ? IDLE : DRAIN;
                end else if (mem_rvalid_i) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (flush_i || drsp_ready_i) begin
                    w_next_state = IDLE;
                end
            end
            DRAIN: begin
                if (mem_rvalid_i) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        dreq_ready_o       = 1'b0;
        areq_o.fetch_req   = 1'b0;
        areq_o.fetch_vaddr = '0;
        mem_req_o          = 1'b0;
        mem_addr_o         = '0;
        drsp_valid_o       = 1'b0;
        drsp_vaddr_o       = '0;
        drsp_data_o        = '0;
        drsp_err_o         = 1'b0;
        case (r_state)
            IDLE: dreq_ready_o = 1'b1;
            XLATE: begin
                areq_o.fetch_req   = 1'b1;
                areq_o.fetch_vaddr = r_vaddr;
            end
            MEM_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = r_paddr;
            end
            RESP: begin
                drsp_valid_o = 1'b1;
                drsp_vaddr_o = r_vaddr;
                drsp_data_o  = r_data;
                drsp_err_o   = r_err;
            end
            default: ;
        endcase
    end

    assign dbg_state_o = r_state;

    // Payload registers; a misaligned or timed-out fetch reports data 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_xlate_cnt <= '0;
            r_vaddr     <= '0;
            r_paddr     <= '0;
            r_data      <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_vaddr     <= dreq_vaddr_i;
                        r_data      <= '0;
                        r_err       <= !is_word_aligned(dreq_vaddr_i);
                        r_xlate_cnt <= '0;
                    end
                end
                XLATE: begin
                    if (!flush_i) begin
                        if (areq_i.fetch_valid) begin
                            r_paddr <= areq_i.fetch_paddr;
                        end else if (w_xlate_expired) begin
                            r_err <= 1'b1;
                        end else begin
                            r_xlate_cnt <= r_xlate_cnt + 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_rvalid_i && !flush_i) begin
                        r_data <= mem_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed bench for icache_fetch_ctrl: expected responses go into a queue,
// a negedge monitor pops and compares each frontend response handshake.
module tb_icache_fetch_ctrl;
    import ariane_pkg::*;

    typedef struct packed {
        logic [63:0] vaddr;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic            dreq_valid_i = 1'b0;
    logic            dreq_ready_o;
    logic [63:0]     dreq_vaddr_i = '0;
    icache_arsp_t    areq_o;
    icache_areq_t    areq_i;
    logic            mem_req_o;
    logic            mem_gnt_i = 1'b0;
    logic [55:0]     mem_addr_o;
    logic            mem_rvalid_i = 1'b0;
    logic [31:0]     mem_rdata_i = '0;
    logic            drsp_valid_o;
    logic            drsp_ready_i = 1'b0;
    logic [63:0]     drsp_vaddr_o;
    logic [31:0]     drsp_data_o;
    logic            drsp_err_o;
    fetch_state_e    dbg_state_o;

    logic            tlb_en = 1'b0;
    logic [55:0]     tlb_paddr = '0;

    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_gnt = 0;
    int   n_mreq = 0;
    int   n_xreq = 0;
    int   n_rspv = 0;

    icache_fetch_ctrl #(.XLATE_TIMEOUT(16)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .dreq_valid_i (dreq_valid_i),
        .dreq_ready_o (dreq_ready_o),
        .dreq_vaddr_i (dreq_vaddr_i),
        .areq_o       (areq_o),
        .areq_i       (areq_i),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_addr_o   (mem_addr_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .drsp_valid_o (drsp_valid_o),
        .drsp_ready_i (drsp_ready_i),
        .drsp_vaddr_o (drsp_vaddr_o),
        .drsp_data_o  (drsp_data_o),
        .drsp_err_o   (drsp_err_o),
        .dbg_state_o  (dbg_state_o)
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    // Combinational TLB model: answers in the same cycle it is asked when enabled.
    always_comb begin
        areq_i.fetch_valid = tlb_en && areq_o.fetch_req;
        areq_i.fetch_paddr = tlb_en ? tlb_paddr : '0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_req(input logic [63:0] va);
        int w;
        w = 0;
        while (!dreq_ready_o && w < 50) begin
            tick();
            w++;
        end
        chk("req_ready_wait", dreq_ready_o, 1'b1);
        dreq_valid_i = 1'b1;
        dreq_vaddr_i = va;
        tick();
        dreq_valid_i = 1'b0;
        dreq_vaddr_i = '0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk_i) begin
        rsp_t e;
        if (rst_ni) begin
            if (mem_req_o && mem_gnt_i) n_gnt++;
            if (mem_req_o) n_mreq++;
            if (areq_o.fetch_req) n_xreq++;
            if (drsp_valid_o) n_rspv++;
            if (drsp_valid_o && drsp_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got vaddr=%0h data=%0h err=%0b expected no response",
                             drsp_vaddr_o, drsp_data_o, drsp_err_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp", {drsp_vaddr_o, drsp_data_o, drsp_err_o}, e);
                end
            end
        end
    end

    initial begin
        int k;
        int base_gnt, base_mreq, base_xreq, base_rspv;
        logic [55:0] pa;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        tick();
        chk("rst_dreq_ready", dreq_ready_o, 1'b1);
        chk("rst_areq", areq_o, '0);
        chk("rst_mem", {mem_req_o, mem_addr_o}, '0);
        chk("rst_drsp", {drsp_valid_o, drsp_vaddr_o, drsp_data_o, drsp_err_o}, '0);

        // Basic fetch: same-cycle TLB, immediate grant, rvalid two cycles after grant
        tlb_en = 1'b1;
        tlb_paddr = 56'h2000;
        mem_gnt_i = 1'b1;
        drsp_ready_i = 1'b1;
        base_gnt = n_gnt;
        base_mreq = n_mreq;
        exp_q.push_back('{vaddr: 64'h1000, data: 32'hDEADBEEF, err: 1'b0});
        do_req(64'h1000);
        chk("basic_areq", {areq_o.fetch_req, areq_o.fetch_vaddr}, {1'b1, 64'h1000});
        tick();
        chk("basic_mem_req", {mem_req_o, mem_addr_o}, {1'b1, 56'h2000});
        tick();
        mem_gnt_i = 1'b0;
        chk("basic_wait_no_req", mem_req_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'hDEADBEEF;
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        chk("basic_rsp_valid", drsp_valid_o, 1'b1);
        tick();
        chk("basic_back_idle", dreq_ready_o, 1'b1);
        chk("basic_one_gnt", n_gnt - base_gnt, 1);
        chk("basic_one_mreq", n_mreq - base_mreq, 1);

        // Misaligned vaddr: error on the next cycle, no TLB or memory traffic
        drsp_ready_i = 1'b0;
        base_xreq = n_xreq;
        base_mreq = n_mreq;
        exp_q.push_back('{vaddr: 64'h1002, data: 32'h0, err: 1'b1});
        do_req(64'h1002);
        chk("misal_rsp", {drsp_valid_o, drsp_err_o, drsp_data_o}, {1'b1, 1'b1, 32'h0});
        drsp_ready_i = 1'b1;
        tick();
        chk("misal_no_xreq", n_xreq - base_xreq, 0);
        chk("misal_no_mreq", n_mreq - base_mreq, 0);

        // Translation timeout after 16 XLATE cycles
        tlb_en = 1'b0;
        exp_q.push_back('{vaddr: 64'h3000, data: 32'h0, err: 1'b1});
        do_req(64'h3000);
        k = 0;
        while (areq_o.fetch_req && k < 100) begin
            k++;
            tick();
        end
        chk("timeout_cycles", k, 16);
        chk("timeout_rsp_state", {drsp_valid_o, drsp_err_o}, 2'b11);
        tick();

        // Grant delayed 5 cycles, then response held while ready is low
        tlb_en = 1'b1;
        pa = 56'h12_3456_789A_BCD0;
        tlb_paddr = pa;
        drsp_ready_i = 1'b0;
        exp_q.push_back('{vaddr: 64'h4000, data: 32'hCAFEF00D, err: 1'b0});
        do_req(64'h4000);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("gnt_wait_stable", {mem_req_o, mem_addr_o}, {1'b1, pa});
            tick();
        end
        mem_gnt_i = 1'b1;
        chk("gnt_cycle_req", {mem_req_o, mem_addr_o}, {1'b1, pa});
        tick();
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'hCAFEF00D;
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        for (int i = 0; i < 3; i++) begin
            chk("rsp_hold", {drsp_valid_o, drsp_vaddr_o, drsp_data_o, drsp_err_o},
                {1'b1, 64'h4000, 32'hCAFEF00D, 1'b0});
            tick();
        end
        drsp_ready_i = 1'b1;
        tick();
        chk("hold_back_idle", dreq_ready_o, 1'b1);

        // Flush in MEM_WAIT, rvalid four cycles later is discarded
        base_rspv = n_rspv;
        mem_gnt_i = 1'b1;
        do_req(64'h5000);
        tick();
        tick();
        mem_gnt_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("drain_not_ready", dreq_ready_o, 1'b0);
        repeat (3) tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'h11111111;
        chk("drain_before_rvalid", dreq_ready_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        chk("drain_ready_after", dreq_ready_o, 1'b1);
        repeat (2) tick();
        chk("drain_no_rsp", n_rspv - base_rspv, 0);

        // Flush in XLATE returns to IDLE next cycle
        tlb_en = 1'b0;
        do_req(64'h6000);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("xlate_flush_idle", {dreq_ready_o, areq_o.fetch_req}, 2'b10);
        chk("xlate_flush_no_rsp", n_rspv - base_rspv, 0);

        // Reset asserted during MEM_REQ
        tlb_en = 1'b1;
        tlb_paddr = 56'h7700;
        mem_gnt_i = 1'b0;
        do_req(64'h7000);
        tick();
        chk("rst_mid_memreq", {mem_req_o, mem_addr_o}, {1'b1, 56'h7700});
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_mid_outputs", {mem_req_o, mem_addr_o, areq_o, drsp_valid_o, drsp_data_o, drsp_err_o}, '0);
        mem_gnt_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        mem_gnt_i = 1'b0;
        base_rspv = n_rspv;
        chk("rst_mid_idle", {dreq_ready_o, dbg_state_o}, {1'b1, IDLE});
        repeat (5) tick();
        chk("rst_mid_no_rsp", n_rspv - base_rspv, 0);
        chk("rst_mid_no_mreq", mem_req_o, 1'b0);

        // Recovery after reset: rvalid in the first MEM_WAIT cycle
        tlb_paddr = 56'h8800;
        mem_gnt_i = 1'b1;
        exp_q.push_back('{vaddr: 64'h8000, data: 32'h0BADF00D, err: 1'b0});
        do_req(64'h8000);
        tick();
        tick();
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'h0BADF00D;
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        repeat (3) tick();

        chk("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
